// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: dispatch/bypass/issue payloads and queue entry.
package alu_issue_queue_pkg;

    localparam int unsigned IQ_DEPTH      = 8;
    localparam int unsigned IQ_NUM_BYPASS = 4;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned PHY_W         = 6;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned ROB_W         = 4;
    localparam int unsigned WE_W          = 4;

    typedef logic [PHY_W-1:0] reg_addr_t;

    typedef struct packed {
        logic [WE_W-1:0]   we;
        reg_addr_t         phy_dest;
        logic [DATA_W-1:0] value;
    } bypass_bus_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        reg_addr_t         phy_dest;
        reg_addr_t         src1_phy;
        reg_addr_t         src2_phy;
        logic              src1_ready;
        logic              src2_ready;
        logic [DATA_W-1:0] src1_value;
        logic [DATA_W-1:0] src2_value;
        logic [ROB_W-1:0]  rob_entry_num;
    } dispatch_to_issue_bus_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        reg_addr_t         phy_dest;
        logic [DATA_W-1:0] src1_value;
        logic [DATA_W-1:0] src2_value;
        logic [ROB_W-1:0]  rob_entry_num;
    } issue_to_execute_bus_t;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        reg_addr_t         phy_dest;
        reg_addr_t         src1_phy;
        reg_addr_t         src2_phy;
        logic              src1_ready;
        logic              src2_ready;
        logic [DATA_W-1:0] src1_value;
        logic [DATA_W-1:0] src2_value;
        logic [ROB_W-1:0]  rob_entry_num;
    } iq_entry_t;

    function automatic iq_entry_t to_entry(input dispatch_to_issue_bus_t d);
        iq_entry_t e;
        e.valid         = 1'b1;
        e.inst          = d.inst;
        e.phy_dest      = d.phy_dest;
        e.src1_phy      = d.src1_phy;
        e.src2_phy      = d.src2_phy;
        e.src1_ready    = d.src1_ready;
        e.src2_ready    = d.src2_ready;
        e.src1_value    = d.src1_value;
        e.src2_value    = d.src2_value;
        e.rob_entry_num = d.rob_entry_num;
        return e;
    endfunction

    function automatic issue_to_execute_bus_t to_issue(input iq_entry_t e);
        issue_to_execute_bus_t o;
        o.inst          = e.inst;
        o.phy_dest      = e.phy_dest;
        o.src1_value    = e.src1_value;
        o.src2_value    = e.src2_value;
        o.rob_entry_num = e.rob_entry_num;
        return o;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch / bypass / issue signal bundle between the pipeline and the ALU issue queue.
interface alu_issue_queue_if
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = IQ_DEPTH,
    parameter int unsigned NUM_BYPASS = IQ_NUM_BYPASS
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                   flush;
    logic                   dispatch_valid;
    dispatch_to_issue_bus_t dispatch_inst;
    logic                   iq_allowin;
    bypass_bus_t            bypass_bus [NUM_BYPASS];
    logic                   issue_to_alu_valid;
    issue_to_execute_bus_t  issue_inst;
    logic [CNT_W-1:0]       iq_count;

    modport master (
        output flush, dispatch_valid, dispatch_inst, bypass_bus,
        input  iq_allowin, issue_to_alu_valid, issue_inst, iq_count
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_inst, bypass_bus,
        output iq_allowin, issue_to_alu_valid, issue_inst, iq_count
    );
endinterface

// File: rtl/alu_issue_queue_oldest_ready_select.sv
// Lowest-index priority picker: request vector -> one-hot grant, index and any-valid.
module alu_issue_queue_oldest_ready_select #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    // Scan downward so the lowest requesting index is the last one written.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_req;
endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: collapsing queue with bypass wakeup and oldest-ready issue.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = IQ_DEPTH,
    parameter int unsigned NUM_BYPASS = IQ_NUM_BYPASS
) (
    input logic              clk,
    input logic              reset,
    alu_issue_queue_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t             r_q [DEPTH];
    logic [CNT_W-1:0]      r_count;

    iq_entry_t             w_woken [DEPTH];
    iq_entry_t             w_next  [DEPTH];
    iq_entry_t             w_new;
    logic [DEPTH-1:0]      w_req;
    logic [DEPTH-1:0]      w_grant;
    logic [IDX_W-1:0]      w_issue_idx;
    logic                  w_issue_any;
    logic                  w_allowin;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_app_idx;
    logic [CNT_W-1:0]      w_count_next;
    issue_to_execute_bus_t w_issue;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_req[i] = r_q[i].valid && r_q[i].src1_ready && r_q[i].src2_ready;
        end
    end

    alu_issue_queue_oldest_ready_select #(.DEPTH(DEPTH)) u_select (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_idx   (w_issue_idx),
        .o_any   (w_issue_any)
    );

    // Wakeup compare per entry x source x bus, plus the same snoop on the incoming dispatch;
    // descending bus scan lets the lowest-numbered matching bus win.
    always_comb begin
        w_new = to_entry(bus.dispatch_inst);
        for (int j = 0; j < int'(DEPTH); j++) begin
            w_woken[j] = r_q[j];
        end
        for (int k = int'(NUM_BYPASS) - 1; k >= 0; k--) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (r_q[j].valid && bus.bypass_bus[k].we != '0) begin
                    if (!r_q[j].src1_ready && bus.bypass_bus[k].phy_dest == r_q[j].src1_phy) begin
                        w_woken[j].src1_ready = 1'b1;
                        w_woken[j].src1_value = bus.bypass_bus[k].value;
                    end
                    if (!r_q[j].src2_ready && bus.bypass_bus[k].phy_dest == r_q[j].src2_phy) begin
                        w_woken[j].src2_ready = 1'b1;
                        w_woken[j].src2_value = bus.bypass_bus[k].value;
                    end
                end
            end
            if (bus.bypass_bus[k].we != '0) begin
                if (!bus.dispatch_inst.src1_ready && bus.bypass_bus[k].phy_dest == bus.dispatch_inst.src1_phy) begin
                    w_new.src1_ready = 1'b1;
                    w_new.src1_value = bus.bypass_bus[k].value;
                end
                if (!bus.dispatch_inst.src2_ready && bus.bypass_bus[k].phy_dest == bus.dispatch_inst.src2_phy) begin
                    w_new.src2_ready = 1'b1;
                    w_new.src2_value = bus.bypass_bus[k].value;
                end
            end
        end
    end

    // Remove issued entry, collapse the entries above it, then append the dispatch at the new tail.
    always_comb begin
        w_allowin    = r_count < CNT_W'(DEPTH);
        w_accept     = bus.dispatch_valid && w_allowin;
        w_app_idx    = r_count - CNT_W'(w_issue_any);
        w_count_next = r_count - CNT_W'(w_issue_any) + CNT_W'(w_accept);
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_next[i] = w_woken[i];
        end
        if (w_issue_any) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                if (i >= int'(w_issue_idx)) begin
                    w_next[i] = w_woken[i + 1];
                end
            end
            w_next[DEPTH-1] = '0;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_accept && i == int'(w_app_idx)) begin
                w_next[i] = w_new;
            end
        end
    end

    always_comb begin
        w_issue = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_grant[i]) begin
                w_issue = to_issue(r_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i] <= w_next[i];
            end
            r_count <= w_count_next;
        end
    end

    assign bus.iq_allowin         = w_allowin;
    assign bus.issue_to_alu_valid = w_issue_any;
    assign bus.issue_inst         = w_issue;
    assign bus.iq_count           = r_count;
endmodule
